hashin_reader: RTL and testbench

- Consumer end of the hashin and nonce FIFOs.
- Pops 64-bit words from the hashin FIFO, hunts for the framing word and reassembles the following 10 words into a 640-bit block header.
- Cross-checks the embedded nonce against the nonce FIFO and presents header plus nonce to the hash core over a valid/ready handshake.
- Sits between the two FIFOs and the SHA-256d core.

---
 rtl/hashin_reader.sv | 127 ++++++++++++
 tb/tb_hashin_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hashin_reader.sv
// Consumer of the hashin and nonce FIFOs: finds the framing word, gathers a
// 640-bit block header, cross-checks its nonce and hands it to the hash core.
module hashin_reader #(
    parameter logic [63:0] FRAME_WORD  = 64'h8000000000000280,
    parameter int          HDR_WORDS   = 10,
    parameter bit          CHECK_NONCE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             hashin_fifo_out_dout,
    input  logic                    hashin_fifo_out_empty,
    output logic                    hashin_fifo_out_re,
    input  logic [31:0]             nonce_fifo_dout,
    input  logic                    nonce_fifo_empty,
    output logic                    nonce_fifo_re,
    input  logic                    stop,
    output logic                    stop_ack_reader,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [HDR_WORDS*64-1:0] hdr_data,
    output logic [31:0]             hdr_nonce,
    output logic                    err_framing,
    output logic                    err_nonce,
    output logic [31:0]             frame_cnt
);

    localparam int HDR_W = HDR_WORDS * 64;
    localparam int CNT_W = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SYNC    = 3'd1;
    localparam logic [2:0] COLLECT = 3'd2;
    localparam logic [2:0] NONCE   = 3'd3;
    localparam logic [2:0] PRESENT = 3'd4;
    localparam logic [2:0] FLUSH   = 3'd5;

    // Handshake: a header transfers on any rising clk edge where hdr_valid and
    // hdr_ready are both high; once raised, hdr_valid stays high with
    // hdr_data/hdr_nonce frozen until that transfer happens.
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             hashin_pop;
    logic             nonce_pop;
    logic             frame_hit;
    logic             nonce_bad;
    logic [31:0]      nonce_swapped;

    // The header carries its nonce little-endian in the last 32 bits.
    assign nonce_swapped = {hdr_data[7:0], hdr_data[15:8], hdr_data[23:16], hdr_data[31:24]};
    assign frame_hit     = (hashin_fifo_out_dout == FRAME_WORD);
    assign nonce_bad     = CHECK_NONCE && (nonce_swapped != nonce_fifo_dout);

    always_comb begin
        state_nxt  = state;
        hashin_pop = 1'b0;
        nonce_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!stop && !hashin_fifo_out_empty) state_nxt = SYNC;
            end
            SYNC: begin
                if (stop) begin
                    state_nxt = FLUSH;
                end else if (!hashin_fifo_out_empty) begin
                    hashin_pop = 1'b1;
                    if (frame_hit) state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (stop) begin
                    state_nxt = FLUSH;
                end else if (!hashin_fifo_out_empty) begin
                    hashin_pop = 1'b1;
                    if (cnt == CNT_W'(HDR_WORDS - 1)) state_nxt = NONCE;
                end
            end
            NONCE: begin
                if (stop) begin
                    state_nxt = FLUSH;
                end else if (!nonce_fifo_empty) begin
                    nonce_pop = 1'b1;
                    state_nxt = nonce_bad ? SYNC : PRESENT;
                end
            end
            PRESENT: begin
                // stop only takes effect once the header has been accepted
                if (hdr_ready) state_nxt = stop ? FLUSH : SYNC;
            end
            FLUSH: begin
                hashin_pop = !hashin_fifo_out_empty;
                nonce_pop  = !nonce_fifo_empty;
                if (hashin_fifo_out_empty && nonce_fifo_empty && !stop) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hashin_fifo_out_re = hashin_pop && !rst;
    assign nonce_fifo_re      = nonce_pop && !rst;
    assign hdr_valid          = (state == PRESENT);
    assign stop_ack_reader    = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hdr_data    <= '0;
            hdr_nonce   <= '0;
            frame_cnt   <= '0;
            err_framing <= 1'b0;
            err_nonce   <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_framing <= (state == SYNC) && hashin_pop && !frame_hit;
            err_nonce   <= (state == NONCE) && nonce_pop && nonce_bad;
            if ((state == SYNC) && hashin_pop && frame_hit) cnt <= '0;
            if ((state == COLLECT) && hashin_pop) begin
                hdr_data <= {hdr_data[HDR_W-65:0], hashin_fifo_out_dout};
                cnt      <= cnt + CNT_W'(1);
            end
            if ((state == NONCE) && nonce_pop) hdr_nonce <= nonce_swapped;
            if ((state == PRESENT) && hdr_ready) frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hashin_reader.sv
// Directed bench for hashin_reader: queue-backed FWFT FIFO models feed the
// reader, a scoreboard checks each presented header against its expectation.
module tb_hashin_reader;

    localparam logic [63:0] FRAME = 64'h8000000000000280;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   hashin_fifo_out_dout;
    logic          hashin_fifo_out_empty;
    logic          hashin_fifo_out_re;
    logic [31:0]   nonce_fifo_dout;
    logic          nonce_fifo_empty;
    logic          nonce_fifo_re;
    logic          stop;
    logic          stop_ack_reader;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [639:0]  hdr_data;
    logic [31:0]   hdr_nonce;
    logic          err_framing;
    logic          err_nonce;
    logic [31:0]   frame_cnt;

    logic [63:0]   hq[$];
    logic [31:0]   nq[$];
    logic [671:0]  exp_q[$];
    logic [671:0]  cur;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            pop_cyc = 0;
    int            valid_cyc = 0;
    int            n_err_framing = 0;
    int            n_err_nonce = 0;
    bit            arm_lat = 1'b0;
    bit            stall_en = 1'b0;
    bit            h_pop = 1'b0;
    bit            n_pop = 1'b0;
    bit            prev_valid = 1'b0;

    hashin_reader dut (
        .clk                  (clk),
        .rst                  (rst),
        .hashin_fifo_out_dout (hashin_fifo_out_dout),
        .hashin_fifo_out_empty(hashin_fifo_out_empty),
        .hashin_fifo_out_re   (hashin_fifo_out_re),
        .nonce_fifo_dout      (nonce_fifo_dout),
        .nonce_fifo_empty     (nonce_fifo_empty),
        .nonce_fifo_re        (nonce_fifo_re),
        .stop                 (stop),
        .stop_ack_reader      (stop_ack_reader),
        .hdr_valid            (hdr_valid),
        .hdr_ready            (hdr_ready),
        .hdr_data             (hdr_data),
        .hdr_nonce            (hdr_nonce),
        .err_framing          (err_framing),
        .err_nonce            (err_nonce),
        .frame_cnt            (frame_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // FIFO models: pops are sampled on the active edge, head/flags move on the falling edge
    always @(posedge clk) begin
        h_pop = hashin_fifo_out_re;
        n_pop = nonce_fifo_re;
        if (hashin_fifo_out_re) begin
            checks++;
            if (hashin_fifo_out_empty) begin
                errors++;
                $display("FAIL hashin_pop_when_empty: re=1 empty=1 required empty=0");
            end
            if (arm_lat && hashin_fifo_out_dout == FRAME) begin
                pop_cyc = cyc;
                arm_lat = 1'b0;
            end
        end
        if (nonce_fifo_re) begin
            checks++;
            if (nonce_fifo_empty) begin
                errors++;
                $display("FAIL nonce_pop_when_empty: re=1 empty=1 required empty=0");
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (h_pop) void'(hq.pop_front());
        if (n_pop) void'(nq.pop_front());
        h_pop = 1'b0;
        n_pop = 1'b0;
        hashin_fifo_out_dout  = (hq.size() > 0) ? hq[0] : 64'd0;
        hashin_fifo_out_empty = (hq.size() == 0) || (stall_en && ($urandom_range(0, 1) == 1));
        nonce_fifo_dout       = (nq.size() > 0) ? nq[0] : 32'd0;
        nonce_fifo_empty      = (nq.size() == 0);
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (err_framing) n_err_framing++;
        if (err_nonce) n_err_nonce++;
        if (hdr_valid && !prev_valid) begin
            valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_hdr: nonce=%h with no header expected", hdr_nonce);
                cur = {hdr_data, hdr_nonce};
            end else begin
                cur = exp_q.pop_front();
                if ({hdr_data, hdr_nonce} !== cur) begin
                    errors++;
                    $display("FAIL hdr_compare: got %h/%h required %h/%h",
                             hdr_data, hdr_nonce, cur[671:32], cur[31:0]);
                end
            end
        end else if (hdr_valid) begin
            checks++;
            if ({hdr_data, hdr_nonce} !== cur) begin
                errors++;
                $display("FAIL hdr_stable: got %h/%h required %h/%h",
                         hdr_data, hdr_nonce, cur[671:32], cur[31:0]);
            end
        end
        prev_valid = hdr_valid;
    end

    // driver tasks
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [63:0] seed, input logic [31:0] n_hdr,
                              input logic [31:0] n_fifo, input bit with_nonce, input bit expect_ok);
        logic [639:0] h;
        logic [63:0]  w;
        h = '0;
        hq.push_back(FRAME);
        for (int j = 0; j < 10; j++) begin
            if (j == 9) w = {32'h1111_2222, n_hdr[7:0], n_hdr[15:8], n_hdr[23:16], n_hdr[31:24]};
            else        w = seed + 64'(j);
            h[639-64*j -: 64] = w;
            hq.push_back(w);
        end
        if (with_nonce) nq.push_back(n_fifo);
        if (expect_ok) exp_q.push_back({h, n_hdr});
    endtask

    task automatic wait_cnt(input logic [31:0] target, input string name);
        int n;
        n = 0;
        while (frame_cnt != target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(frame_cnt), 64'(target));
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while ((hq.size() != 0 || nq.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(hq.size() + nq.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        stop = 1'b0;
        hdr_ready = 1'b0;
        hashin_fifo_out_dout = '0;
        hashin_fifo_out_empty = 1'b1;
        nonce_fifo_dout = '0;
        nonce_fifo_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
        check("rst_stop_ack", 64'(stop_ack_reader), 64'd1);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst_pops", 64'({hashin_fifo_out_re, nonce_fifo_re}), 64'd0);
        rst = 1'b0;

        // single frame plus latency
        hdr_ready = 1'b1;
        arm_lat = 1'b1;
        push_frame(64'h0000_0001_0000_0000, 32'h12345678, 32'h12345678, 1'b1, 1'b1);
        wait_cnt(32'd1, "single_frame_cnt");
        check("single_latency", 64'(valid_cyc - pop_cyc), 64'd12);
        check("single_nonce", 64'(hdr_nonce), 64'h12345678);
        check("single_no_errs", 64'(n_err_framing + n_err_nonce), 64'd0);

        // garbage ahead of a frame
        hq.push_back(64'hDEAD_BEEF_0000_0000);
        hq.push_back(64'h0);
        push_frame(64'h0000_0002_0000_0100, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b1, 1'b1);
        wait_cnt(32'd2, "garbage_frame_cnt");
        check("garbage_err_framing", 64'(n_err_framing), 64'd2);

        // nonce mismatch drops a header, next one goes through
        push_frame(64'h0000_0003_0000_0200, 32'h00000005, 32'h00000006, 1'b1, 1'b0);
        push_frame(64'h0000_0004_0000_0300, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1);
        wait_cnt(32'd3, "mismatch_frame_cnt");
        check("mismatch_err_nonce", 64'(n_err_nonce), 64'd1);

        // random empty stalls on the hashin FIFO
        stall_en = 1'b1;
        push_frame(64'h0000_0005_0000_0400, 32'h0BADC0DE, 32'h0BADC0DE, 1'b1, 1'b1);
        wait_cnt(32'd4, "stall_frame_cnt");
        stall_en = 1'b0;

        // hold ready low for 50 cycles
        hdr_ready = 1'b0;
        push_frame(64'h0000_0006_0000_0500, 32'h55AA33CC, 32'h55AA33CC, 1'b1, 1'b1);
        for (int n = 0; n < 400 && !hdr_valid; n++) @(negedge clk);
        check("bp_valid_seen", 64'(hdr_valid), 64'd1);
        repeat (50) @(negedge clk);
        check("bp_cnt_held", 64'(frame_cnt), 64'd4);
        check("bp_valid_held", 64'(hdr_valid), 64'd1);
        hdr_ready = 1'b1;
        wait_cnt(32'd5, "bp_frame_cnt");
        repeat (5) @(negedge clk);
        check("bp_single_inc", 64'(frame_cnt), 64'd5);

        // stop after 4 payload words, 6 words + 1 nonce still to come
        hq.push_back(FRAME);
        for (int j = 0; j < 4; j++) hq.push_back(64'h0000_0007_0000_0000 + 64'(j));
        wait_drained("stop_pre_drain");
        repeat (2) @(negedge clk);
        stop = 1'b1;
        for (int j = 4; j < 10; j++) hq.push_back(64'h0000_0007_0000_0000 + 64'(j));
        nq.push_back(32'h77777777);
        wait_drained("stop_flush_drain");
        repeat (3) @(negedge clk);
        check("stop_ack_while_stop", 64'(stop_ack_reader), 64'd0);
        stop = 1'b0;
        repeat (2) @(negedge clk);
        check("stop_ack_idle", 64'(stop_ack_reader), 64'd1);
        check("stop_frame_cnt", 64'(frame_cnt), 64'd5);
        check("stop_no_errs", 64'(n_err_framing + n_err_nonce), 64'd3);

        // reset while waiting for a nonce
        push_frame(64'h0000_0008_0000_0000, 32'h01020304, 32'h01020304, 1'b0, 1'b0);
        wait_drained("rst_pre_drain");
        repeat (3) @(negedge clk);
        check("nonce_wait_no_valid", 64'(hdr_valid), 64'd0);
        check("nonce_wait_state", 64'(dut.state), 64'd3);
        nq.push_back(32'h01020304);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_state", 64'(dut.state), 64'd0);
        check("rst2_stop_ack", 64'(stop_ack_reader), 64'd1);
        check("rst2_frame_cnt", 64'(frame_cnt), 64'd0);
        check("rst2_hdr_data", 64'(|hdr_data), 64'd0);
        check("rst2_outs", 64'({hdr_valid, hdr_nonce, err_framing, err_nonce}), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst2_nonce_kept", 64'(nq.size()), 64'd1);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
